// File: rtl/boot_pkg.sv
// Shared types and helpers for the power-up memory initialiser (boot_loader).
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_LATCH = 3'd2,
        ST_WRITE = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [7:0]  FILL_DEFAULT  = 8'hFF;
    localparam int unsigned SZ_MAX_IMAGES = 256;
    localparam int unsigned SZ_VECW       = 4 * SZ_MAX_IMAGES;

    // log2 byte size of image n from the packed 4-bit-per-image size vector
    function automatic logic [3:0] sz(input logic [SZ_VECW-1:0] sizes, input int unsigned n);
        if (n >= SZ_MAX_IMAGES) begin
            return 4'd0;
        end
        return sizes[4*n +: 4];
    endfunction

endpackage

// File: rtl/boot_decode.sv
// Destination address decode: which image slot, ROM offset, and whether the byte comes from ROM.
module boot_decode
    import boot_pkg::*;
#(
    parameter int unsigned       AW     = 19,
    parameter int unsigned       SLOTW  = 15,
    parameter int unsigned       IMAGES = 3,
    parameter logic [4*IMAGES-1:0] SIZES = {4'd13, 4'd15, 4'd14},
    parameter int unsigned       SELW   = (IMAGES > 1) ? $clog2(IMAGES) : 1
) (
    input  logic [AW-1:0]    i_addr,
    output logic             o_is_img,
    output logic [SELW-1:0]  o_rom_sel,
    output logic [SLOTW-1:0] o_rom_a
);

    localparam int unsigned SLOT_BITS = AW - SLOTW;

    logic [SLOT_BITS-1:0] w_slot;
    logic [SLOTW-1:0]     w_off;
    logic [3:0]           w_size;
    logic [SLOTW:0]       w_lim;
    logic                 w_in_range;

    assign w_slot     = i_addr[AW-1:SLOTW];
    assign w_off      = i_addr[SLOTW-1:0];
    assign w_in_range = (32'(w_slot) < IMAGES);
    assign w_size     = sz(SZ_VECW'(SIZES), 32'(w_slot));
    // limit is one bit wider than the offset so a full-slot image (size == SLOTW) fits
    assign w_lim      = (SLOTW+1)'(1) << w_size;

    assign o_is_img  = w_in_range && ({1'b0, w_off} < w_lim);
    assign o_rom_sel = SELW'(w_slot);
    assign o_rom_a   = w_off;

endmodule

// File: rtl/boot_loader.sv
// Power-up memory initialiser: walks 0..2**AW-1, copies ROM images into slots, fills the rest.
// Optional checksum output enabled by defining BOOT_LOADER_CHECKSUM_EN.
module boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned         AW     = 19,
    parameter int unsigned         SLOTW  = 15,
    parameter int unsigned         IMAGES = 3,
    parameter logic [4*IMAGES-1:0] SIZES  = {4'd13, 4'd15, 4'd14},
    parameter logic [7:0]          FILL   = FILL_DEFAULT,
    parameter int unsigned         SELW   = (IMAGES > 1) ? $clog2(IMAGES) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [SELW-1:0]  romSel,
    output logic [SLOTW-1:0] romA,
    input  logic [7:0]       romQ,
    output logic             wr,
    output logic [AW-1:0]    wrA,
    output logic [7:0]       wrD,
    input  logic             wrRdy
`ifdef BOOT_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]      sum
`endif
);

    localparam logic [AW-1:0] ADDR_LAST = '1;

    state_t           r_state, w_state_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_wr, w_wr_nxt;
    logic [AW-1:0]    r_wrA, w_wrA_nxt;
    logic [7:0]       r_wrD, w_wrD_nxt;
    logic [SELW-1:0]  r_romSel, w_romSel_nxt;
    logic [SLOTW-1:0] r_romA, w_romA_nxt;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [15:0]      r_sum, w_sum_nxt;
`endif

    logic [AW-1:0]    w_dec_a;
    logic             w_is_img;
    logic [SELW-1:0]  w_dec_sel;
    logic [SLOTW-1:0] w_dec_a_off;

    // In NEXT the ROM address for the following byte is set up early, so the
    // registered ROM has its data ready by the time LATCH samples romQ.
    assign w_dec_a = (r_state == ST_NEXT) ? (r_wrA + AW'(1)) : r_wrA;

    boot_decode #(
        .AW     (AW),
        .SLOTW  (SLOTW),
        .IMAGES (IMAGES),
        .SIZES  (SIZES),
        .SELW   (SELW)
    ) u_decode (
        .i_addr    (w_dec_a),
        .o_is_img  (w_is_img),
        .o_rom_sel (w_dec_sel),
        .o_rom_a   (w_dec_a_off)
    );

    // Next-state and datapath update; everything holds while enable is low.
    always_comb begin
        w_state_nxt  = r_state;
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_done;
        w_wr_nxt     = r_wr;
        w_wrA_nxt    = r_wrA;
        w_wrD_nxt    = r_wrD;
        w_romSel_nxt = r_romSel;
        w_romA_nxt   = r_romA;
`ifdef BOOT_LOADER_CHECKSUM_EN
        w_sum_nxt    = r_sum;
`endif
        if (enable) begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_SEL;
                    w_busy_nxt  = 1'b1;
                end
                ST_SEL: begin
                    if (w_is_img) begin
                        w_romSel_nxt = w_dec_sel;
                        w_romA_nxt   = w_dec_a_off;
                        w_state_nxt  = ST_LATCH;
                    end else begin
                        w_wrD_nxt   = FILL;
                        w_wr_nxt    = 1'b1;
                        w_state_nxt = ST_WRITE;
                    end
                end
                ST_LATCH: begin
                    w_wrD_nxt   = romQ;
                    w_wr_nxt    = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
                ST_WRITE: begin
                    if (wrRdy) begin
                        w_wr_nxt    = 1'b0;
                        w_state_nxt = ST_NEXT;
`ifdef BOOT_LOADER_CHECKSUM_EN
                        w_sum_nxt   = r_sum + 16'(r_wrD);
`endif
                    end
                end
                ST_NEXT: begin
                    if (r_wrA == ADDR_LAST) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_wrA_nxt   = r_wrA + AW'(1);
                        w_state_nxt = ST_SEL;
                        if (w_is_img) begin
                            w_romSel_nxt = w_dec_sel;
                            w_romA_nxt   = w_dec_a_off;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        w_wrA_nxt    = '0;
                        w_romSel_nxt = '0;
                        w_romA_nxt   = '0;
                        w_done_nxt   = 1'b0;
                        w_busy_nxt   = 1'b1;
                        w_state_nxt  = ST_SEL;
`ifdef BOOT_LOADER_CHECKSUM_EN
                        w_sum_nxt    = '0;
`endif
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wr     <= 1'b0;
            r_wrA    <= '0;
            r_wrD    <= '0;
            r_romSel <= '0;
            r_romA   <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_sum    <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_wr     <= w_wr_nxt;
            r_wrA    <= w_wrA_nxt;
            r_wrD    <= w_wrD_nxt;
            r_romSel <= w_romSel_nxt;
            r_romA   <= w_romA_nxt;
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_sum    <= w_sum_nxt;
`endif
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign wr     = r_wr;
    assign wrA    = r_wrA;
    assign wrD    = r_wrD;
    assign romSel = r_romSel;
    assign romA   = r_romA;
`ifdef BOOT_LOADER_CHECKSUM_EN
    assign sum    = r_sum;
`endif

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: AW=6, SLOTW=4, two images (8 and 16 bytes), FILL=FF.
module tb_boot_loader;

    localparam int unsigned AW     = 6;
    localparam int unsigned SLOTW  = 4;
    localparam int unsigned IMAGES = 2;
    localparam int unsigned NADDR  = 64;

    logic             clock = 1'b0;
    logic             reset, enable, start, wrRdy;
    logic             busy, done, wr;
    logic [0:0]       romSel;
    logic [SLOTW-1:0] romA;
    logic [7:0]       romQ = 8'h00;
    logic [AW-1:0]    wrA;
    logic [7:0]       wrD;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [15:0]      sum;
`endif

    always #5 clock = ~clock;

    boot_loader #(
        .AW     (AW),
        .SLOTW  (SLOTW),
        .IMAGES (IMAGES),
        .SIZES  (8'h43),
        .FILL   (8'hFF)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .romSel (romSel),
        .romA   (romA),
        .romQ   (romQ),
        .wr     (wr),
        .wrA    (wrA),
        .wrD    (wrD),
        .wrRdy  (wrRdy)
`ifdef BOOT_LOADER_CHECKSUM_EN
        ,
        .sum    (sum)
`endif
    );

    // Registered ROM: image n byte k = {n, k[3:0]}
    always @(posedge clock) romQ <= 8'({romSel, romA[3:0]});

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    logic [7:0] mem [NADDR];
    int         cnt [NADDR];
    int         last_a, ord_err, n_acc;

    task automatic clear_mon();
        for (int i = 0; i < int'(NADDR); i++) begin
            mem[i] = 8'h00;
            cnt[i] = 0;
        end
        last_a  = -1;
        ord_err = 0;
        n_acc   = 0;
    endtask

    // Accepted-write monitor, sampled mid-cycle before the accepting edge
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && enable && wr && wrRdy) begin
                if (int'(wrA) != last_a + 1) ord_err++;
                last_a = int'(wrA);
                cnt[wrA]++;
                mem[wrA] = wrD;
                n_acc++;
            end
        end
    end

    function automatic logic [7:0] exp_byte(input int a);
        if (a < 8)  return 8'(a);
        if (a < 16) return 8'hFF;
        if (a < 32) return 8'(a);
        return 8'hFF;
    endfunction

    function automatic logic [31:0] snap();
        return 32'({busy, done, wr, wrA, wrD, romSel, romA});
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 3000) begin
            tick();
            k++;
        end
        chk({tag, " done_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic wait_addr(input logic [AW-1:0] a, input logic need_wr, input string tag);
        int k = 0;
        while (!(wrA == a && (wr || !need_wr)) && k < 3000) begin
            tick();
            k++;
        end
        chk({tag, " addr_timeout"}, 32'(wrA), 32'(a));
    endtask

    task automatic check_load(input string tag);
        int bad_d = 0;
        int bad_c = 0;
        int esum  = 0;
        for (int a = 0; a < int'(NADDR); a++) begin
            if (mem[a] !== exp_byte(a)) bad_d++;
            if (cnt[a] != 1) bad_c++;
            esum += int'(exp_byte(a));
        end
        chk({tag, " bad_data"}, 32'(bad_d), 32'd0);
        chk({tag, " bad_count"}, 32'(bad_c), 32'd0);
        chk({tag, " order_err"}, 32'(ord_err), 32'd0);
        chk({tag, " n_acc"}, 32'(n_acc), 32'(NADDR));
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, " wr_at_done"}, 32'(wr), 32'd0);
`ifdef BOOT_LOADER_CHECKSUM_EN
        chk({tag, " sum"}, 32'(sum), 32'(esum & 16'hFFFF));
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int bad;
        logic [31:0] s0;

        reset  = 1'b1;
        enable = 1'b0;
        start  = 1'b0;
        wrRdy  = 1'b0;
        clear_mon();
        repeat (3) tick();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst wr", 32'(wr), 32'd0);
        chk("rst wrA", 32'(wrA), 32'd0);
        chk("rst wrD", 32'(wrD), 32'd0);
        chk("rst rom", 32'({romSel, romA}), 32'd0);
`ifdef BOOT_LOADER_CHECKSUM_EN
        chk("rst sum", 32'(sum), 32'd0);
`endif

        // Scenario 1: free-running load
        reset  = 1'b0;
        enable = 1'b1;
        wrRdy  = 1'b1;
        tick();
        chk("autostart busy", 32'(busy), 32'd1);
        chk("autostart done", 32'(done), 32'd0);
        wait_done("s1");
        check_load("s1");

        // Scenario 4 + 2: reload at done, stall on 0x12, start while busy
        clear_mon();
        pulse_start();
        chk("s4 done_fall", 32'(done), 32'd0);
        chk("s4 busy_rise", 32'(busy), 32'd1);
`ifdef BOOT_LOADER_CHECKSUM_EN
        chk("s4 sum_clear", 32'(sum), 32'd0);
`endif
        wait_addr(6'h12, 1'b0, "s2");
        wrRdy = 1'b0;
        wait_addr(6'h12, 1'b1, "s2w");
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (wr !== 1'b1 || wrA !== 6'h12 || wrD !== 8'h12) bad++;
            if (i < 4) tick();
        end
        chk("s2 stall_hold", 32'(bad), 32'd0);
        chk("s2 no_accept", 32'(cnt[6'h12]), 32'd0);
        wrRdy = 1'b1;
        tick();
        chk("s2 wr_drop", 32'(wr), 32'd0);
        wait_addr(6'h13, 1'b1, "s2n");
        chk("s2 next_wrD", 32'(wrD), 32'h13);
        pulse_start();
        chk("s4 start_busy", 32'(busy), 32'd1);
        wait_done("s2");
        check_load("s2");

        // Scenario 3: freeze with a pending write mid-image
        clear_mon();
        pulse_start();
        wait_addr(6'h05, 1'b1, "s3");
        s0     = snap();
        enable = 1'b0;
        bad    = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (snap() !== s0) bad++;
        end
        chk("s3 frozen", 32'(bad), 32'd0);
        chk("s3 no_accept", 32'(cnt[6'h05]), 32'd0);
        enable = 1'b1;
        wait_done("s3");
        check_load("s3");

        // Scenario 5: reset during a pending write at 0x15
        clear_mon();
        pulse_start();
        wait_addr(6'h15, 1'b1, "s5");
        reset = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s5 wr", 32'(wr), 32'd0);
        chk("s5 wrA", 32'(wrA), 32'd0);
        chk("s5 wrD", 32'(wrD), 32'd0);
        chk("s5 busy", 32'(busy), 32'd0);
        chk("s5 done", 32'(done), 32'd0);
        chk("s5 rom", 32'({romSel, romA}), 32'd0);
        reset = 1'b0;
        clear_mon();
        wait_done("s5");
        check_load("s5");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
